// File: rtl/vend_core_param.sv
// vend_core_param: N-product vending FSM with coin credit, refund and timed vend/change display; define VEND_CHANGE_EN to allow overpayment with change
module vend_core_param #(
  parameter int                  N_PROD     = 4,
  parameter logic [N_PROD*8-1:0] PRICES     = {8'd40, 8'd30, 8'd20, 8'd15},
  parameter int                  N_COIN     = 3,
  parameter logic [N_COIN*8-1:0] COIN_VALS  = {8'd25, 8'd10, 8'd5},
  parameter int                  CREDIT_MAX = 99,
  parameter int                  HOLD_TICKS = 1000
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              tick,
  input  logic [N_PROD-1:0] sel,
  input  logic [N_COIN-1:0] coin,
  input  logic              vend_btn,
  input  logic              cancel_btn,
  output logic [N_PROD-1:0] leds,
  output logic [7:0]        left_disp,
  output logic [7:0]        right_disp,
  output logic              coin_reject,
  output logic              err,
  output logic [1:0]        state_o
);
  localparam int PW = N_PROD > 1 ? $clog2(N_PROD) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, VEND = 2'd1, CHANGE = 2'd2} state_t;
  state_t r_state, w_state;
  logic [7:0] r_credit, w_credit, r_change, w_change, w_price, w_coin_val;
  logic [PW-1:0] r_prod, w_prod, w_sel_idx;
  logic [HW-1:0] r_hold, w_hold;
  logic [N_COIN-1:0] r_coin_prev, w_coin_edge;
  logic r_vend_prev, r_cancel_prev, r_rej, w_rej, r_err, w_err;
  logic w_vend_edge, w_cancel_edge, w_sel_ok, w_pay_ok, w_hold_done;
  logic [8:0] w_sum;

  function automatic logic [7:0] bcd(input logic [7:0] v);
    return {4'(v / 8'd10), 4'(v % 8'd10)};
  endfunction

  // button edges, selected product price and the lowest-index coin edge value
  always_comb begin
    w_coin_edge   = coin & ~r_coin_prev;
    w_vend_edge   = vend_btn & ~r_vend_prev;
    w_cancel_edge = cancel_btn & ~r_cancel_prev;
    w_sel_ok      = $onehot(sel);
    w_sel_idx     = '0;
    w_price       = '0;
    w_coin_val    = '0;
    for (int i = N_PROD - 1; i >= 0; i--)
      if (sel[i]) begin
        w_sel_idx = PW'(i);
        w_price   = PRICES[8*i +: 8];
      end
    for (int i = N_COIN - 1; i >= 0; i--)
      if (w_coin_edge[i]) w_coin_val = COIN_VALS[8*i +: 8];
    w_sum       = {1'b0, r_credit} + {1'b0, w_coin_val};
    w_hold_done = r_hold == HW'(HOLD_TICKS - 1);
`ifdef VEND_CHANGE_EN
    w_pay_ok    = r_credit >= w_price;
`else
    w_pay_ok    = r_credit == w_price;
`endif
  end

  // next-state logic: credit handling in IDLE, timed VEND/CHANGE phases
  always_comb begin
    w_state  = r_state;
    w_credit = r_credit;
    w_change = r_change;
    w_prod   = r_prod;
    w_hold   = w_hold_done ? '0 : r_hold + HW'(1);
    w_rej    = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      IDLE: begin
        w_hold = '0;
        if (w_cancel_edge) begin
          w_change = r_credit;
          w_credit = '0;
          w_state  = CHANGE;
        end else if (|w_coin_edge) begin
          if (w_sum <= 9'(CREDIT_MAX)) w_credit = w_sum[7:0];
          else w_rej = 1'b1;
        end else if (w_vend_edge) begin
          if (w_sel_ok && w_pay_ok) begin
            w_change = r_credit - w_price;
            w_credit = '0;
            w_prod   = w_sel_idx;
            w_state  = VEND;
          end else w_err = 1'b1;
        end
      end
`ifdef VEND_CHANGE_EN
      VEND: if (w_hold_done) w_state = CHANGE;
`else
      VEND: if (w_hold_done) w_state = IDLE;
`endif
      CHANGE: if (w_hold_done) begin
        w_state  = IDLE;
        w_change = '0;
      end
      default: w_state = IDLE;
    endcase
  end

  // state and sampled-button registers advance only on tick; pulses hold until the next tick
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      r_state       <= IDLE;
      r_credit      <= '0;
      r_change      <= '0;
      r_prod        <= '0;
      r_hold        <= '0;
      r_coin_prev   <= '0;
      r_vend_prev   <= 1'b0;
      r_cancel_prev <= 1'b0;
      r_rej         <= 1'b0;
      r_err         <= 1'b0;
    end else if (tick) begin
      r_state       <= w_state;
      r_credit      <= w_credit;
      r_change      <= w_change;
      r_prod        <= w_prod;
      r_hold        <= w_hold;
      r_coin_prev   <= coin;
      r_vend_prev   <= vend_btn;
      r_cancel_prev <= cancel_btn;
      r_rej         <= w_rej;
      r_err         <= w_err;
    end

  assign leds        = r_state == VEND ? N_PROD'(1) << r_prod : '0;
  assign left_disp   = r_state == CHANGE ? bcd(r_change) : (r_state == IDLE && w_sel_ok) ? bcd(w_price) : 8'h00;
  assign right_disp  = bcd(r_credit);
  assign coin_reject = r_rej;
  assign err         = r_err;
  assign state_o     = r_state;
endmodule
